// File: rtl/tmds_decoder.sv
// tmds_decoder: receive-side TMDS channel decoder.
// Recovers symbol alignment from a free-running 10-bit deserializer using runs
// of control tokens, monitors lock, and decodes pixel data / control bits.
// Optional build macro: TMDS_DECODER_STATS_EN adds lock_loss_count and
// slip_offset status outputs.
module tmds_decoder #(
    parameter int LOCK_RUN      = 16,
    parameter int SEARCH_WINDOW = 2048,
    parameter int LOSS_WINDOW   = 4096
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] in_sym,
    output logic [7:0] out_data,
    output logic [1:0] out_ctrl,
    output logic       out_de,
    output logic       out_valid
`ifdef TMDS_DECODER_STATS_EN
    ,
    output logic [7:0] lock_loss_count,
    output logic [3:0] slip_offset
`endif
);

    localparam int RUN_W   = $clog2(LOCK_RUN + 1);
    localparam int WIN_MAX = (SEARCH_WINDOW > LOSS_WINDOW) ? SEARCH_WINDOW : LOSS_WINDOW;
    localparam int WIN_W   = (WIN_MAX > 1) ? $clog2(WIN_MAX) : 1;

    localparam logic [0:0] ST_SEARCH = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [9:0]       r_prev;
    logic [9:0]       r_sym;
    logic [3:0]       r_offset;
    logic [0:0]       r_state;
    logic [RUN_W-1:0] r_run_cnt;
    logic [WIN_W-1:0] r_win_cnt;

    logic [19:0]      w_win;
    logic [19:0]      w_shift;
    logic             w_is_tok;
    logic [1:0]       w_tok_code;
    logic [7:0]       w_q;
    logic [7:0]       w_d;
    logic             w_run_hit;
    logic             w_search_exp;
    logic             w_loss_exp;

    // Earlier word sits in the low half so bit 0 stays the earliest wire bit.
    assign w_win   = {in_sym, r_prev};
    assign w_shift = w_win >> r_offset;

    // Capture the previous raw word and the aligned symbol.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev <= '0;
            r_sym  <= '0;
        end else begin
            r_prev <= in_sym;
            r_sym  <= w_shift[9:0];
        end
    end

    // Control token detection on the aligned symbol.
    always_comb begin
        w_is_tok   = 1'b1;
        w_tok_code = 2'b00;
        case (r_sym)
            10'h354: w_tok_code = 2'b00;
            10'h0AB: w_tok_code = 2'b01;
            10'h154: w_tok_code = 2'b10;
            10'h2AB: w_tok_code = 2'b11;
            default: w_is_tok   = 1'b0;
        endcase
    end

    // Data decode: undo the optional inversion, then the XOR/XNOR chain.
    always_comb begin
        w_q    = r_sym[9] ? ~r_sym[7:0] : r_sym[7:0];
        w_d    = '0;
        w_d[0] = w_q[0];
        for (int i = 1; i < 8; i++) begin
            w_d[i] = r_sym[8] ? (w_q[i] ^ w_q[i-1]) : ~(w_q[i] ^ w_q[i-1]);
        end
    end

    // run_hit fires only on the token that brings the run up to LOCK_RUN.
    assign w_run_hit    = w_is_tok && (r_run_cnt == RUN_W'(LOCK_RUN - 1));
    assign w_search_exp = (r_win_cnt == WIN_W'(SEARCH_WINDOW - 1));
    assign w_loss_exp   = (r_win_cnt == WIN_W'(LOSS_WINDOW - 1));

`ifdef TMDS_DECODER_STATS_EN
    logic [7:0] r_loss_cnt;
    assign lock_loss_count = r_loss_cnt;
    assign slip_offset     = r_offset;
`endif

    // Alignment search / lock monitor FSM with its run and window counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_SEARCH;
            r_offset  <= '0;
            r_run_cnt <= '0;
            r_win_cnt <= '0;
`ifdef TMDS_DECODER_STATS_EN
            r_loss_cnt <= '0;
`endif
        end else begin
            if (!w_is_tok)
                r_run_cnt <= '0;
            else if (r_run_cnt != RUN_W'(LOCK_RUN))
                r_run_cnt <= r_run_cnt + 1'b1;

            case (r_state)
                ST_SEARCH: begin
                    // A completed run wins over a coinciding window expiry.
                    if (w_run_hit) begin
                        r_state   <= ST_LOCKED;
                        r_win_cnt <= '0;
                    end else if (w_search_exp) begin
                        r_offset  <= (r_offset == 4'd9) ? 4'd0 : r_offset + 4'd1;
                        r_run_cnt <= '0;
                        r_win_cnt <= '0;
                    end else begin
                        r_win_cnt <= r_win_cnt + 1'b1;
                    end
                end
                default: begin
                    // Offset is frozen while locked; loss keeps it for a fast relock.
                    if (w_run_hit) begin
                        r_win_cnt <= '0;
                    end else if (w_loss_exp) begin
                        r_state   <= ST_SEARCH;
                        r_run_cnt <= '0;
                        r_win_cnt <= '0;
`ifdef TMDS_DECODER_STATS_EN
                        if (r_loss_cnt != 8'hFF)
                            r_loss_cnt <= r_loss_cnt + 8'd1;
`endif
                    end else begin
                        r_win_cnt <= r_win_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // Registered outputs; out_ctrl keeps the last control code during video.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_de    <= 1'b0;
            out_data  <= '0;
            out_ctrl  <= '0;
        end else if (r_state != ST_LOCKED) begin
            out_valid <= 1'b0;
            out_de    <= 1'b0;
            out_data  <= '0;
            out_ctrl  <= '0;
        end else begin
            out_valid <= 1'b1;
            if (w_is_tok) begin
                out_de   <= 1'b0;
                out_data <= '0;
                out_ctrl <= w_tok_code;
            end else begin
                out_de   <= 1'b1;
                out_data <= w_d;
            end
        end
    end

endmodule
